// File: rtl/ppt_fire_sequencer_pkg.sv
// ppt_pkg: shared state encoding, default widths and register-map reset config
package ppt_pkg;
  localparam int DIV_W  = 5;
  localparam int TIME_W = 14;
  localparam int CNT_W  = 8;
  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;
  localparam logic [DIV_W-1:0]  CLK_DIV = DIV_W'(9);
  localparam logic [TIME_W-1:0] PERIOD  = TIME_W'(128);
  localparam logic [TIME_W-1:0] WIDTH   = TIME_W'(1);
  localparam logic [CNT_W-1:0]  COUNT   = CNT_W'(16);
endpackage

// File: rtl/ppt_fire_sequencer_if.sv
// ppt_fire_sequencer_if: config/run from the register map, progress back to it
interface ppt_fire_sequencer_if #(
  parameter int DIV_W  = ppt_pkg::DIV_W,
  parameter int TIME_W = ppt_pkg::TIME_W,
  parameter int CNT_W  = ppt_pkg::CNT_W
);
  logic [DIV_W-1:0]  clk_div;
  logic [TIME_W-1:0] period;
  logic [TIME_W-1:0] width;
  logic [CNT_W-1:0]  count;
  logic              run;
  logic              pulse_out;
  logic [CNT_W-1:0]  count_done;
  logic              done;
  logic              busy;
  modport master (output clk_div, period, width, count, run, input pulse_out, count_done, done, busy);
  modport slave  (input clk_div, period, width, count, run, output pulse_out, count_done, done, busy);
endinterface

// File: rtl/ppt_prescaler.sv
// ppt_prescaler: one-cycle tick every 2**(clk_div+1) enabled cycles
module ppt_prescaler #(
  parameter int DIV_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick
);
  localparam int CW = 2 ** DIV_W;
  localparam logic [CW-1:0] ONES = '1;
  logic [CW-1:0] cnt_q, cnt_d, mask;
  // mask covers bits [clk_div:0]; tick when those bits are all ones
  always_comb begin
    mask = ONES >> (DIV_W'(CW - 1) - clk_div);
    tick = en && ((cnt_q & mask) == mask);
    cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  end
  // free-running prescale counter
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ppt_fire_sequencer.sv
// ppt_fire_sequencer: timed PPT fire pulse train driven by latched register-map config
module ppt_fire_sequencer #(
  parameter int DIV_W  = ppt_pkg::DIV_W,
  parameter int TIME_W = ppt_pkg::TIME_W,
  parameter int CNT_W  = ppt_pkg::CNT_W
) (
  input logic                 clk,
  input logic                 rstn,
  ppt_fire_sequencer_if.slave bus
);
  import ppt_pkg::*;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [TIME_W-1:0] per_q, per_d, wid_q, wid_d, tcnt_q, tcnt_d, wid_eff;
  logic [CNT_W-1:0] num_q, num_d, cnt_done_q, cnt_done_d;
  logic pulse_q, pulse_d, done_q, done_d, busy_q, busy_d;
  logic tick, active, degen;
  assign active = state_q == PULSE || state_q == GAP;
  assign wid_eff = (bus.width > bus.period - TIME_W'(1)) ? bus.period - TIME_W'(1) : bus.width;
  assign degen = bus.period < TIME_W'(2) || bus.width == '0 || bus.count == '0;
  assign bus.pulse_out = pulse_q;
  assign bus.count_done = cnt_done_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  ppt_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (!active),
    .en     (active),
    .clk_div(div_q),
    .tick   (tick)
  );
  // sequencer next state: latch config on start, count ticks through pulse and gap
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    per_d = per_q;
    wid_d = wid_q;
    num_d = num_q;
    tcnt_d = tcnt_q;
    cnt_done_d = cnt_done_q;
    pulse_d = pulse_q;
    done_d = done_q;
    busy_d = busy_q;
    case (state_q)
      IDLE: if (bus.run) begin
        div_d = bus.clk_div;
        per_d = bus.period;
        wid_d = wid_eff;
        num_d = bus.count;
        cnt_done_d = '0;
        tcnt_d = '0;
        state_d = degen ? DONE : PULSE;
        pulse_d = !degen;
        busy_d = !degen;
        done_d = degen;
      end
      PULSE, GAP: if (!bus.run) begin
        state_d = IDLE;
        pulse_d = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
      end else if (tick) begin
        tcnt_d = tcnt_q + TIME_W'(1);
        if (state_q == PULSE && tcnt_q == wid_q - TIME_W'(1)) begin
          pulse_d = 1'b0;
          cnt_done_d = cnt_done_q + CNT_W'(1);
          state_d = GAP;
        end
        if (state_q == GAP && tcnt_q == per_q - TIME_W'(1)) begin
          if (cnt_done_q == num_q) begin
            state_d = DONE;
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            tcnt_d = '0;
            pulse_d = 1'b1;
            state_d = PULSE;
          end
        end
      end
      DONE: if (!bus.run) begin
        state_d = IDLE;
        done_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, latched config and registered outputs
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      div_q <= '0;
      per_q <= '0;
      wid_q <= '0;
      num_q <= '0;
      tcnt_q <= '0;
      cnt_done_q <= '0;
      pulse_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      per_q <= per_d;
      wid_q <= wid_d;
      num_q <= num_d;
      tcnt_q <= tcnt_d;
      cnt_done_q <= cnt_done_d;
      pulse_q <= pulse_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
endmodule

// File: tb/tb_ppt_fire_sequencer.sv
// tb_ppt_fire_sequencer: directed and random fire sequences against a timing model
module tb_ppt_fire_sequencer;
  import ppt_pkg::*;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int errors = 0;
  int checks = 0;
  ppt_fire_sequencer_if bus ();
  ppt_fire_sequencer dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(string tag, int k, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, got, exp);
    end
  endtask

  // expected outputs k cycles after the start edge, from the pulse-train timing rules
  function automatic void model(int k, int dv, int per, int wid, int cnt,
                                output int p, output int cd, output int d, output int b);
    int t, we, pt, total;
    t = 2 << dv;
    we = (wid > per - 1) ? per - 1 : wid;
    if (per < 2 || wid == 0 || cnt == 0) begin
      p = 0; cd = 0; d = 1; b = 0;
      return;
    end
    pt = per * t;
    total = cnt * pt;
    d = (k >= total) ? 1 : 0;
    b = 1 - d;
    p = (d == 0 && (k % pt) < we * t) ? 1 : 0;
    cd = (k < we * t) ? 0 : (k - we * t) / pt + 1;
    if (cd > cnt) cd = cnt;
  endfunction

  // start a sequence, check every cycle, optionally rewrite the inputs mid-run, then drop run
  task automatic seq(int dv, int per, int wid, int cnt, int ncyc, int mut_at);
    int p, cd, d, b;
    cd = 0;
    bus.clk_div = DIV_W'(dv);
    bus.period = TIME_W'(per);
    bus.width = TIME_W'(wid);
    bus.count = CNT_W'(cnt);
    bus.run = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      model(k, dv, per, wid, cnt, p, cd, d, b);
      chk("pulse_out", k, bus.pulse_out, p);
      chk("count_done", k, bus.count_done, cd);
      chk("done", k, bus.done, d);
      chk("busy", k, bus.busy, b);
      if (k == mut_at) begin
        bus.period = TIME_W'(100);
        bus.width = TIME_W'($urandom_range(1, 50));
        bus.count = CNT_W'($urandom_range(1, 9));
        bus.clk_div = DIV_W'($urandom_range(0, 3));
      end
    end
    bus.run = 1'b0;
    @(negedge clk);
    chk("drop_pulse", ncyc, bus.pulse_out, 0);
    chk("drop_done", ncyc, bus.done, 0);
    chk("drop_busy", ncyc, bus.busy, 0);
    chk("drop_count_done", ncyc, bus.count_done, cd);
  endtask

  initial begin
    int dv, per, wid, cnt, full, n;
    bus.clk_div = CLK_DIV;
    bus.period = PERIOD;
    bus.width = WIDTH;
    bus.count = COUNT;
    bus.run = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pulse", 0, bus.pulse_out, 0);
    chk("rst_count_done", 0, bus.count_done, 0);
    chk("rst_done", 0, bus.done, 0);
    chk("rst_busy", 0, bus.busy, 0);
    rstn = 1'b1;
    @(negedge clk);
    // basic train: T=2, 3 pulses of 2 cycles every 8, done at start+24, then held
    seq(0, 4, 1, 3, 28, -1);
    // width clamp: width_eff=2, done at start+6
    seq(0, 3, 10, 1, 9, -1);
    // abort mid third pulse, then restart with count_done cleared
    seq(1, 10, 5, 5, 91, -1);
    chk("abort_count_done", 0, bus.count_done, 2);
    seq(1, 10, 5, 5, 6, -1);
    // degenerate configurations
    seq(0, 4, 1, 0, 3, -1);
    seq(0, 1, 1, 3, 3, -1);
    seq(0, 4, 0, 3, 3, -1);
    // inputs rewritten mid-run are ignored; no refire while run stays high
    seq(0, 4, 1, 2, 24, 5);
    seq(0, 100, 1, 1, 210, -1);
    // asynchronous reset during a pulse
    bus.clk_div = '0;
    bus.period = TIME_W'(4);
    bus.width = TIME_W'(1);
    bus.count = CNT_W'(3);
    bus.run = 1'b1;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("arst_pulse", 0, bus.pulse_out, 0);
    chk("arst_count_done", 0, bus.count_done, 0);
    chk("arst_done", 0, bus.done, 0);
    chk("arst_busy", 0, bus.busy, 0);
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_pulse", i, bus.pulse_out, 0);
      chk("post_rst_busy", i, bus.busy, 0);
    end
    seq(0, 4, 1, 3, 27, -1);
    // random configurations, alternately run to completion or aborted at a random point
    for (int i = 0; i < 10; i++) begin
      dv = $urandom_range(0, 2);
      per = $urandom_range(1, 12);
      wid = $urandom_range(0, 14);
      cnt = $urandom_range(0, 4);
      full = cnt * per * (2 << dv) + 3;
      n = (i % 2 == 1) ? $urandom_range(1, full) : full;
      seq(dv, per, wid, cnt, n, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
